// File: rtl/vga_timing.sv
// Raster timing generator: free-running pixel/line counters decoded into
// registered sync, blanking, pixel-strobe and position outputs, all aligned.
module vga_timing #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        reset_n,
    input  logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        fb_hblank,
    output logic        fb_vblank,
    output logic        next_n,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
    // Sync windows are half-open [start, end); back porch >= 1 keeps end in range.
    localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;

    logic hblank_d;
    logic vblank_d;
    logic hsync_d;
    logic vsync_d;
    logic next_n_d;
    logic line_start_d;
    logic frame_start_d;

    // Pixel and line counters; vc steps only on the hc wrap.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
        end else begin
            hc <= hc + CW'(1);
        end
    end

    // Decode of the current counter values; registered below.
    always_comb begin
        hblank_d      = 1'b1;
        vblank_d      = 1'b1;
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        next_n_d      = 1'b1;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        hblank_d = (hc >= H_ACT);
        vblank_d = (vc >= V_ACT);
        if ((hc >= HS_START) && (hc < HS_END)) begin
            hsync_d = HSYNC_POL;
        end
        // vsync depends on the line counter only, so it moves at x==0.
        if ((vc >= VS_START) && (vc < VS_END)) begin
            vsync_d = VSYNC_POL;
        end
        next_n_d      = ~(~hblank_d & ~vblank_d);
        line_start_d  = (hc == '0);
        frame_start_d = (hc == '0) && (vc == '0);
    end

    // Output register: one clock behind the counters, every port a flop.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_pos       <= '0;
            y_pos       <= '0;
            fb_hblank   <= 1'b1;
            fb_vblank   <= 1'b1;
            next_n      <= 1'b1;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x_pos       <= hc;
            y_pos       <= vc;
            fb_hblank   <= hblank_d;
            fb_vblank   <= vblank_d;
            next_n      <= next_n_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default mode, a small high-polarity mode and
// a default-horizontal/short-vertical mode, all clocked together.
module tb_vga_timing;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic ra_n, rb_n, rc_n;

    logic a_hs, a_vs, a_hb, a_vb, a_nn, a_ls, a_fs;
    logic b_hs, b_vs, b_hb, b_vb, b_nn, b_ls, b_fs;
    logic c_hs, c_vs, c_hb, c_vb, c_nn, c_ls, c_fs;
    logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;

    vga_timing u_a (
        .reset_n(ra_n), .vga_clk(vga_clk), .hsync(a_hs), .vsync(a_vs),
        .fb_hblank(a_hb), .fb_vblank(a_vb), .next_n(a_nn), .x_pos(a_x),
        .y_pos(a_y), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_b (
        .reset_n(rb_n), .vga_clk(vga_clk), .hsync(b_hs), .vsync(b_vs),
        .fb_hblank(b_hb), .fb_vblank(b_vb), .next_n(b_nn), .x_pos(b_x),
        .y_pos(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_c (
        .reset_n(rc_n), .vga_clk(vga_clk), .hsync(c_hs), .vsync(c_vs),
        .fb_hblank(c_hb), .fb_vblank(c_vb), .next_n(c_nn), .x_pos(c_x),
        .y_pos(c_y), .line_start(c_ls), .frame_start(c_fs)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Reference decode from output coordinates: {hs,vs,hb,vb,nn,ls,fs,x,y}.
    function automatic logic [28:0] model(input int x, input int y,
                                          input int ha, input int hfp, input int hsw,
                                          input int va, input int vfp, input int vsw,
                                          input bit hp, input bit vp);
        logic hb, vb, hs, vs;
        hb = (x >= ha);
        vb = (y >= va);
        hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hp : ~hp;
        vs = (y >= va + vfp && y < va + vfp + vsw) ? vp : ~vp;
        return {hs, vs, hb, vb, ~(~hb & ~vb), (x == 0), (x == 0 && y == 0), 11'(x), 11'(y)};
    endfunction

    int a_mis, b_mis, c_mis, blank_strobe;
    int a_hb_rise, a_hb_run, a_hs_low, a_hs_first, a_hs_last, a_ls_cnt;
    int b_hs_cnt, b_hs_first, b_vs_cnt, b_vs_first, b_strobe, b_ls2, b_fs2;
    int c_vb_k, c_vb_x, c_vb_y, c_vs_low, c_vs_first, c_vs_last, c_strobe, c_fs2;
    int c_pre_y, c_pre_x, c_post_y;
    int n;

    initial begin
        {a_mis, b_mis, c_mis, blank_strobe} = '0;
        a_hb_rise = -1; a_hb_run = 0; a_hs_low = 0; a_hs_first = -1; a_hs_last = -1; a_ls_cnt = 0;
        b_hs_cnt = 0; b_hs_first = -1; b_vs_cnt = 0; b_vs_first = -1; b_strobe = 0; b_ls2 = -1; b_fs2 = -1;
        c_vb_k = -1; c_vb_x = -1; c_vb_y = -1; c_vs_low = 0; c_vs_first = -1; c_vs_last = -1;
        c_strobe = 0; c_fs2 = -1; c_pre_y = -1; c_pre_x = -1; c_post_y = -1;

        ra_n = 1'b0; rb_n = 1'b0; rc_n = 1'b0;
        repeat (5) step();
        chk("rst_a", {a_hs, a_vs, a_hb, a_vb, a_nn, a_ls, a_fs, a_x, a_y},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0});
        chk("rst_b_syncs", {b_hs, b_vs}, 2'b00);

        @(negedge vga_clk);
        ra_n = 1'b1; rb_n = 1'b1; rc_n = 1'b1;
        step();
        chk("rel_a", {a_nn, a_hb, a_vb, a_ls, a_fs, a_x, a_y},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 11'd0});

        for (int k = 0; k < 6500; k++) begin
            if ({a_hs, a_vs, a_hb, a_vb, a_nn, a_ls, a_fs, a_x, a_y} !==
                model(k % 800, (k / 800) % 525, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0)) a_mis++;
            if ({b_hs, b_vs, b_hb, b_vb, b_nn, b_ls, b_fs, b_x, b_y} !==
                model(k % 14, (k / 14) % 7, 8, 2, 3, 4, 1, 1, 1'b1, 1'b1)) b_mis++;
            if ({c_hs, c_vs, c_hb, c_vb, c_nn, c_ls, c_fs, c_x, c_y} !==
                model(k % 800, (k / 800) % 8, 640, 16, 96, 4, 1, 2, 1'b0, 1'b0)) c_mis++;
            if (!a_nn && (a_hb || a_vb)) blank_strobe++;
            if (!b_nn && (b_hb || b_vb)) blank_strobe++;
            if (!c_nn && (c_hb || c_vb)) blank_strobe++;

            if (k < 800) begin
                if (a_hb && a_hb_rise < 0) a_hb_rise = int'(a_x);
                if (!a_hb && a_hb_rise < 0) a_hb_run++;
                if (!a_hs) begin
                    a_hs_low++;
                    if (a_hs_first < 0) a_hs_first = int'(a_x);
                    a_hs_last = int'(a_x);
                end
            end
            if (k < 1600 && a_ls) a_ls_cnt++;
            if (k == 800) chk("a_wrap", {a_ls, a_x, a_y}, {1'b1, 11'd0, 11'd1});

            if (k < 14 && b_hs) begin
                b_hs_cnt++;
                if (b_hs_first < 0) b_hs_first = int'(b_x);
            end
            if (k < 98) begin
                if (b_vs) begin
                    b_vs_cnt++;
                    if (b_vs_first < 0) b_vs_first = k;
                end
                if (!b_nn) b_strobe++;
            end
            if (k > 0 && b_ls && b_ls2 < 0) b_ls2 = k;
            if (k > 0 && b_fs && b_fs2 < 0) b_fs2 = k;

            if (c_vb && c_vb_k < 0) begin
                c_vb_k = k; c_vb_x = int'(c_x); c_vb_y = int'(c_y);
            end
            if (k < 6400) begin
                if (!c_vs) begin
                    c_vs_low++;
                    if (c_vs_first < 0) c_vs_first = int'(c_y);
                    c_vs_last = int'(c_y);
                end
                if (!c_nn) c_strobe++;
            end
            if (k > 0 && c_fs && c_fs2 < 0) c_fs2 = k;
            if (k == 6399) begin c_pre_y = int'(c_y); c_pre_x = int'(c_x); end
            if (k == 6400) c_post_y = int'(c_y);
            step();
        end

        chk("a_model", a_mis, 0);
        chk("b_model", b_mis, 0);
        chk("c_model", c_mis, 0);
        chk("strobe_in_blank", blank_strobe, 0);
        chk("a_hblank_rise_x", a_hb_rise, 640);
        chk("a_hblank_low_run", a_hb_run, 640);
        chk("a_hsync_low_cnt", a_hs_low, 96);
        chk("a_hsync_first_x", a_hs_first, 656);
        chk("a_hsync_last_x", a_hs_last, 751);
        chk("a_line_start_cnt", a_ls_cnt, 2);
        chk("b_hsync_hi_cnt", b_hs_cnt, 3);
        chk("b_hsync_first_x", b_hs_first, 10);
        chk("b_vsync_hi_cnt", b_vs_cnt, 14);
        chk("b_vsync_first_k", b_vs_first, 70);
        chk("b_strobe_cnt", b_strobe, 32);
        chk("b_line_period", b_ls2, 14);
        chk("b_frame_period", b_fs2, 98);
        chk("c_vblank_rise_k", c_vb_k, 3200);
        chk("c_vblank_rise_xy", {c_vb_x[15:0], c_vb_y[15:0]}, {16'd0, 16'd4});
        chk("c_vsync_low_cnt", c_vs_low, 1600);
        chk("c_vsync_first_y", c_vs_first, 5);
        chk("c_vsync_last_y", c_vs_last, 6);
        chk("c_strobe_cnt", c_strobe, 2560);
        chk("c_frame_period", c_fs2, 6400);
        chk("c_y_wrap", {c_pre_y[15:0], c_pre_x[15:0], c_post_y[15:0]}, {16'd7, 16'd799, 16'd0});

        // Mid-frame reset on A and B while A sits at x=300.
        n = 0;
        while (a_x != 11'd300 && n < 2000) begin
            step();
            n++;
        end
        chk("mid_wait_bound", (n < 2000), 1);
        ra_n = 1'b0; rb_n = 1'b0;
        #1;
        chk("mid_rst_a", {a_hs, a_vs, a_hb, a_vb, a_nn, a_ls, a_fs, a_x, a_y},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0});
        chk("mid_rst_b", {b_hs, b_vs, b_hb, b_vb, b_nn, b_x, b_y},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0});
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        ra_n = 1'b1; rb_n = 1'b1;
        step();
        chk("mid_rel_a", {a_fs, a_ls, a_x, a_y}, {1'b1, 1'b1, 11'd0, 11'd0});

        a_mis = 0; b_mis = 0; b_fs2 = -1;
        for (int k = 0; k < 1700; k++) begin
            if ({a_hs, a_vs, a_hb, a_vb, a_nn, a_ls, a_fs, a_x, a_y} !==
                model(k % 800, (k / 800) % 525, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0)) a_mis++;
            if ({b_hs, b_vs, b_hb, b_vb, b_nn, b_ls, b_fs, b_x, b_y} !==
                model(k % 14, (k / 14) % 7, 8, 2, 3, 4, 1, 1, 1'b1, 1'b1)) b_mis++;
            if (k > 0 && b_fs && b_fs2 < 0) b_fs2 = k;
            step();
        end
        chk("a_model_after_rst", a_mis, 0);
        chk("b_model_after_rst", b_mis, 0);
        chk("b_frame_after_rst", b_fs2, 98);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
